// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-master SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StDone
    } state_e;

    localparam int unsigned LAT_W = 2;

    // Drop the byte offset; the caller keeps only the low ADDR_W bits.
    function automatic logic [29:0] byte_to_word(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select. SRAM_ARB_RR_EN selects round-robin; otherwise port 0 wins ties.
module sram_arb_pick (
    input  logic m0_valid_i,
    input  logic m1_valid_i,
    input  logic grant_i,
    output logic req_o,
    output logic sel_o
);

    assign req_o = m0_valid_i | m1_valid_i;

`ifdef SRAM_ARB_RR_EN
    // On a tie the port that did not own the last transaction goes next.
    assign sel_o = (m0_valid_i && m1_valid_i) ? ~grant_i : m1_valid_i;
`else
    logic unused_grant;
    assign unused_grant = grant_i;
    assign sel_o        = ~m0_valid_i & m1_valid_i;
`endif

endmodule

// File: rtl/sram_mem_arbiter.sv
// Two-master arbiter for one single-port SRAM macro; SRAM_ARB_RR_EN enables round-robin.
module sram_mem_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic [31:0]       m0_rdata,
    output logic              m0_ready,
    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic [31:0]       m1_rdata,
    output logic              m1_ready,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              busy,
    output logic              grant
);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               grant_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic [31:0]        m0_rdata_q, m1_rdata_q;
    logic               m0_ready_q, m1_ready_q;

    logic               pick_req, pick_sel;
    logic               accept, capture, wr_done;
    logic [29:0]        req_word;

    sram_arb_pick u_pick (
        .m0_valid_i (m0_valid),
        .m1_valid_i (m1_valid),
        .grant_i    (grant_q),
        .req_o      (pick_req),
        .sel_o      (pick_sel)
    );

    assign req_word = byte_to_word(pick_sel ? m1_addr : m0_addr);

    logic unused_addr;
    assign unused_addr = ^{req_word[29:ADDR_W], m0_addr[1:0], m1_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        wr_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_req) begin
                    accept  = 1'b1;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (wstrb_q != 4'b0) begin
                    wr_done = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d   = LAT_W'(RD_LAT - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            grant_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                grant_q <= pick_sel;
                addr_q  <= req_word[ADDR_W-1:0];
                wdata_q <= pick_sel ? m1_wdata : m0_wdata;
                wstrb_q <= pick_sel ? m1_wstrb : m0_wstrb;
            end
            // Ready is registered so it lines up exactly with the DONE state.
            m0_ready_q <= (state_d == StDone) && !grant_q;
            m1_ready_q <= (state_d == StDone) && grant_q;
            if (capture) begin
                if (grant_q) m1_rdata_q <= sram_rdata;
                else         m0_rdata_q <= sram_rdata;
            end else if (wr_done) begin
                if (grant_q) m1_rdata_q <= '0;
                else         m0_rdata_q <= '0;
            end
        end
    end

    assign sram_en    = (state_q == StAccess);
    assign sram_we    = sram_en ? wstrb_q : 4'b0;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign busy       = (state_q != StIdle);
    assign grant      = grant_q;
    assign m0_ready   = m0_ready_q;
    assign m1_ready   = m1_ready_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Directed and random checks of sram_mem_arbiter at RD_LAT = 1, 2 and 3.
module tb_sram_mem_arbiter;

    localparam int N = 3;

    logic        clk;
    logic        reset;
    logic        m0_valid [N];
    logic [31:0] m0_addr  [N];
    logic [31:0] m0_wdata [N];
    logic [3:0]  m0_wstrb [N];
    logic [31:0] m0_rdata [N];
    logic        m0_ready [N];
    logic        m1_valid [N];
    logic [31:0] m1_addr  [N];
    logic [31:0] m1_wdata [N];
    logic [3:0]  m1_wstrb [N];
    logic [31:0] m1_rdata [N];
    logic        m1_ready [N];
    logic        sram_en  [N];
    logic [3:0]  sram_we  [N];
    logic [7:0]  sram_addr[N];
    logic [31:0] sram_wdata[N];
    logic [31:0] sram_rdata[N];
    logic        busy     [N];
    logic        grant    [N];

    int errors = 0;
    int checks = 0;
    int last_grant [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned LAT = g + 1;
        logic [31:0] mem  [256];
        logic [31:0] pipe [LAT];

        sram_mem_arbiter #(.ADDR_W(8), .RD_LAT(LAT)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .m0_valid   (m0_valid[g]),
            .m0_addr    (m0_addr[g]),
            .m0_wdata   (m0_wdata[g]),
            .m0_wstrb   (m0_wstrb[g]),
            .m0_rdata   (m0_rdata[g]),
            .m0_ready   (m0_ready[g]),
            .m1_valid   (m1_valid[g]),
            .m1_addr    (m1_addr[g]),
            .m1_wdata   (m1_wdata[g]),
            .m1_wstrb   (m1_wstrb[g]),
            .m1_rdata   (m1_rdata[g]),
            .m1_ready   (m1_ready[g]),
            .sram_en    (sram_en[g]),
            .sram_we    (sram_we[g]),
            .sram_addr  (sram_addr[g]),
            .sram_wdata (sram_wdata[g]),
            .sram_rdata (sram_rdata[g]),
            .busy       (busy[g]),
            .grant      (grant[g])
        );

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
            for (int i = 0; i < int'(LAT); i++) pipe[i] = 32'hBADBAD00;
        end

        // Behavioural macro: data is only meaningful exactly LAT cycles after a read enable.
        always @(posedge clk) begin
            if (sram_en[g]) begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[g][b]) mem[sram_addr[g]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
            end
            pipe[0] <= (sram_en[g] && sram_we[g] == 4'b0) ? mem[sram_addr[g]] : 32'hBADBAD00;
            for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        end

        assign sram_rdata[g] = pipe[LAT-1];
    end

    function automatic logic [112:0] outs(input int i);
        return {busy[i], grant[i], m0_ready[i], m1_ready[i], sram_en[i], sram_we[i],
                sram_addr[i], sram_wdata[i], m0_rdata[i], m1_rdata[i]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic drive(input int inst, input int port, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st);
        if (port == 0) begin
            m0_valid[inst] = v; m0_addr[inst] = a; m0_wdata[inst] = wd; m0_wstrb[inst] = st;
        end else begin
            m1_valid[inst] = v; m1_addr[inst] = a; m1_wdata[inst] = wd; m1_wstrb[inst] = st;
        end
    endtask

    // One transaction; lat/en_k count negedges from the sampling cycle (-1 = never seen).
    task automatic do_txn(input int inst, input int port, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st, output int lat,
                          output int en_k, output logic [7:0] en_addr, output logic [3:0] en_we,
                          output logic [31:0] rd);
        lat = -1; en_k = -1; en_addr = '0; en_we = '0; rd = '0;
        @(posedge clk); #1;
        drive(inst, port, 1'b1, a, wd, st);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sram_en[inst] && en_k < 0) begin
                en_k = k; en_addr = sram_addr[inst]; en_we = sram_we[inst];
            end
            if (port == 0 ? m0_ready[inst] : m1_ready[inst]) begin
                lat = k;
                rd  = (port == 0) ? m0_rdata[inst] : m1_rdata[inst];
                break;
            end
        end
        @(posedge clk); #1;
        drive(inst, port, 1'b0, 32'h0, 32'h0, 4'h0);
        if (lat >= 0) last_grant[inst] = port;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (outs(i) !== '0) begin
                $display("FAIL reset_outputs inst=%0d got=%h want=0", i, outs(i));
                errors++;
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) last_grant[i] = 0;
    endtask

    task automatic test_reset_mid_read;
        int lat, en_k; logic [7:0] ea; logic [3:0] ew; logic [31:0] rd;
        int seen;
        do_txn(2, 1, 32'h8, 32'h55667788, 4'hF, lat, en_k, ea, ew, rd);
        @(posedge clk); #1;
        drive(2, 0, 1'b1, 32'h8, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy[2] !== 1'b1) begin
            $display("FAIL midrd_busy_in_wait got=%b want=1", busy[2]);
            errors++;
        end
        reset = 1'b1;
        drive(2, 0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (outs(2) !== '0) begin
            $display("FAIL midrd_outputs got=%h want=0", outs(2));
            errors++;
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (m0_ready[2] || m1_ready[2] || busy[2]) seen++;
        end
        checks++;
        if (seen !== 0) begin
            $display("FAIL midrd_no_ready got=%0d want=0", seen);
            errors++;
        end
        for (int i = 0; i < N; i++) last_grant[i] = 0;
    endtask

    task automatic test_write_read;
        int lat, en_k; logic [7:0] ea; logic [3:0] ew; logic [31:0] rd;
        do_txn(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, lat, en_k, ea, ew, rd);
        checks++;
        if (lat !== 2 || en_k !== 1) begin
            $display("FAIL wr_latency got lat=%0d en=%0d want lat=2 en=1", lat, en_k);
            errors++;
        end
        checks++;
        if (ea !== 8'h04 || ew !== 4'hF || rd !== 32'h0) begin
            $display("FAIL wr_fields got addr=%h we=%h rdata=%h want 04 f 0", ea, ew, rd);
            errors++;
        end
        do_txn(1, 0, 32'h10, 32'h0, 4'h0, lat, en_k, ea, ew, rd);
        checks++;
        if (lat !== 4 || en_k !== 1 || ew !== 4'h0) begin
            $display("FAIL rd_latency got lat=%0d en=%0d we=%h want 4 1 0", lat, en_k, ew);
            errors++;
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            $display("FAIL rd_data got=%h want=deadbeef", rd);
            errors++;
        end
    endtask

    task automatic test_byte_strobe;
        int lat, en_k; logic [7:0] ea; logic [3:0] ew; logic [31:0] rd;
        do_txn(1, 1, 32'h20, 32'h11223344, 4'hF, lat, en_k, ea, ew, rd);
        do_txn(1, 1, 32'h20, 32'h0000AA00, 4'h2, lat, en_k, ea, ew, rd);
        checks++;
        if (ew !== 4'h2 || lat !== 2) begin
            $display("FAIL strobe_we got we=%h lat=%0d want 2 2", ew, lat);
            errors++;
        end
        do_txn(1, 1, 32'h20, 32'h0, 4'h0, lat, en_k, ea, ew, rd);
        checks++;
        if (rd !== 32'h1122AA44) begin
            $display("FAIL strobe_merge got=%h want=1122aa44", rd);
            errors++;
        end
    endtask

    task automatic test_back_to_back;
        int n, prev_k, port, exp_port;
        logic [31:0] got, want;
        n = 0; prev_k = -1;
        @(posedge clk); #1;
        drive(1, 0, 1'b1, 32'h10, 32'h0, 4'h0);
        drive(1, 1, 1'b1, 32'h20, 32'h0, 4'h0);
        for (int k = 0; k < 80 && n < 4; k++) begin
            @(negedge clk);
            if (m0_ready[1] && m1_ready[1]) begin
                checks++;
                $display("FAIL arb_both_ready k=%0d got=both want=one", k);
                errors++;
            end else if (m0_ready[1] || m1_ready[1]) begin
                port = m1_ready[1] ? 1 : 0;
`ifdef SRAM_ARB_RR_EN
                exp_port = 1 - last_grant[1];
`else
                exp_port = 0;
`endif
                got  = port ? m1_rdata[1] : m0_rdata[1];
                want = port ? 32'h1122AA44 : 32'hDEADBEEF;
                checks++;
                if (port !== exp_port || grant[1] !== 1'(port)) begin
                    $display("FAIL arb_owner n=%0d got port=%0d grant=%b want port=%0d",
                             n, port, grant[1], exp_port);
                    errors++;
                end
                checks++;
                if (got !== want) begin
                    $display("FAIL arb_data n=%0d got=%h want=%h", n, got, want);
                    errors++;
                end
                if (n > 0) begin
                    checks++;
                    if (k - prev_k !== 5) begin
                        $display("FAIL arb_gap n=%0d got=%0d want=5", n, k - prev_k);
                        errors++;
                    end
                end
                last_grant[1] = port;
                prev_k = k;
                n++;
            end
        end
        checks++;
        if (n !== 4) begin
            $display("FAIL arb_count got=%0d want=4", n);
            errors++;
        end
        @(posedge clk); #1;
        drive(1, 0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_alias_latency;
        int lat, en_k; logic [7:0] ea; logic [3:0] ew; logic [31:0] rd;
        for (int i = 0; i < N; i++) begin
            do_txn(i, 0, 32'h4, 32'hA5A50000 + 32'(i), 4'hF, lat, en_k, ea, ew, rd);
            do_txn(i, 0, 32'h0000_0404, 32'h0, 4'h0, lat, en_k, ea, ew, rd);
            checks++;
            if (ea !== 8'h01 || ew !== 4'h0) begin
                $display("FAIL alias_addr lat=%0d got=%h we=%h want=01 0", i + 1, ea, ew);
                errors++;
            end
            checks++;
            if (lat !== 3 + i) begin
                $display("FAIL lat_sweep rd_lat=%0d got=%0d want=%0d", i + 1, lat, 3 + i);
                errors++;
            end
            checks++;
            if (rd !== 32'hA5A50000 + 32'(i)) begin
                $display("FAIL alias_data rd_lat=%0d got=%h want=%h", i + 1, rd,
                         32'hA5A50000 + 32'(i));
                errors++;
            end
        end
    endtask

    // Each random master owns its own 16 words so the model order is per master only.
    logic [31:0] model   [256];
    bit          written [256];
    bit          mon_on = 0;
    int          en_cnt = 0, rdy_cnt = 0, viol = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (sram_en[1]) en_cnt++;
            if (m0_ready[1]) rdy_cnt++;
            if (m1_ready[1]) rdy_cnt++;
            if (sram_en[1] && (m0_ready[1] || m1_ready[1])) viol++;
            if (m0_ready[1] && (m1_ready[1] || grant[1] !== 1'b0)) viol++;
            if (m1_ready[1] && grant[1] !== 1'b1) viol++;
        end
    end

    task automatic rand_master(input int port, input int n);
        int w, idle, hit;
        logic [31:0] wd, got, want;
        logic [3:0] st;
        @(posedge clk); #1;
        for (int t = 0; t < n; t++) begin
            w = 64 + port * 16 + int'($urandom_range(0, 15));
            if (!written[w] || $urandom_range(0, 1) == 1) begin
                wd = $urandom;
                st = written[w] ? 4'($urandom_range(1, 15)) : 4'hF;
                model[w] = merge(model[w], wd, st);
                written[w] = 1'b1;
                want = 32'h0;
            end else begin
                wd = 32'h0; st = 4'h0; want = model[w];
            end
            drive(1, port, 1'b1, 32'(w) << 2, wd, st);
            hit = 0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (port == 0 ? m0_ready[1] : m1_ready[1]) begin
                    hit = 1;
                    got = (port == 0) ? m0_rdata[1] : m1_rdata[1];
                    break;
                end
            end
            checks++;
            if (hit == 0) begin
                $display("FAIL rand_timeout port=%0d t=%0d got=no_ready want=ready", port, t);
                errors++;
            end else begin
                checks++;
                if (got !== want) begin
                    $display("FAIL rand_data port=%0d word=%0d got=%h want=%h", port, w, got,
                             want);
                    errors++;
                end
            end
            @(posedge clk); #1;
            drive(1, port, 1'b0, 32'h0, 32'h0, 4'h0);
            idle = int'($urandom_range(0, 2));
            repeat (idle) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 256; i++) begin
            model[i] = 32'h0; written[i] = 1'b0;
        end
        mon_on = 1;
        fork
            rand_master(0, 30);
            rand_master(1, 30);
        join
        repeat (4) @(negedge clk);
        mon_on = 0;
        checks++;
        if (viol !== 0) begin
            $display("FAIL rand_protocol got=%0d violations want=0", viol);
            errors++;
        end
        checks++;
        if (en_cnt !== rdy_cnt || en_cnt !== 60) begin
            $display("FAIL rand_en_per_ready got en=%0d ready=%0d want 60 60", en_cnt, rdy_cnt);
            errors++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            drive(i, 0, 1'b0, 32'h0, 32'h0, 4'h0);
            drive(i, 1, 1'b0, 32'h0, 32'h0, 4'h0);
            last_grant[i] = 0;
        end
        test_reset;
        test_reset_mid_read;
        test_write_read;
        test_byte_strobe;
        test_back_to_back;
        test_alias_latency;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
